// File: rtl/clk_divider_bank.sv
// Bank of NCH runtime-programmable clock-enable dividers with shadowed, glitch-free reconfiguration.
// Optional DIVBANK_PHASE_ALIGN_EN adds an align input that restarts every channel in phase.
module clk_divider_bank #(
  parameter int NCH        = 3,
  parameter int CW         = 16,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 5
) (
  input  logic           clk_input,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           load,
  input  logic [2:0]     load_ch,
  input  logic [CW-1:0]  load_period,
  input  logic [CW-1:0]  load_high,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] cfg_pending
`ifdef DIVBANK_PHASE_ALIGN_EN
  ,
  input  logic           align
`endif
);

  localparam logic [CW-1:0] MIN_P = CW'(2);
  localparam logic [CW-1:0] RST_P = (DEF_PERIOD < 2) ? MIN_P : CW'(DEF_PERIOD);
  localparam logic [CW-1:0] RST_H = CW'(DEF_HIGH);

  logic          align_i;
  logic [CW-1:0] ld_p;

`ifdef DIVBANK_PHASE_ALIGN_EN
  assign align_i = align;
`else
  assign align_i = 1'b0;
`endif

  // Periods below 2 cannot produce a wrap distinct from the period start.
  assign ld_p = (load_period < MIN_P) ? MIN_P : load_period;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] act_p;
    logic [CW-1:0] act_h;
    logic [CW-1:0] sh_p;
    logic [CW-1:0] sh_h;
    logic          pend;
    logic          clk_r;
    logic          tick_r;
    logic          hit;
    logic          wrap;
    logic          apply_now;

    always_comb begin
      hit       = load && (load_ch == 3'(i));
      wrap      = en[i] && (cnt == act_p - CW'(1));
      apply_now = wrap || align_i;
    end

    always_ff @(posedge clk_input) begin
      if (rst) begin
        cnt    <= '0;
        act_p  <= RST_P;
        act_h  <= RST_H;
        sh_p   <= RST_P;
        sh_h   <= RST_H;
        pend   <= 1'b0;
        clk_r  <= 1'b0;
        tick_r <= 1'b0;
      end else begin
        clk_r  <= en[i] && (cnt < act_h);
        tick_r <= en[i] && (cnt == '0);

        if (!en[i] || apply_now) cnt <= '0;
        else                     cnt <= cnt + CW'(1);

        if (hit) begin
          sh_p <= ld_p;
          sh_h <= load_high;
        end

        // At a boundary a coincident load bypasses the shadow and never shows as pending.
        if (apply_now) begin
          if (hit) begin
            act_p <= ld_p;
            act_h <= load_high;
          end else if (pend) begin
            act_p <= sh_p;
            act_h <= sh_h;
          end
          pend <= 1'b0;
        end else begin
          if (!en[i] && pend) begin
            act_p <= sh_p;
            act_h <= sh_h;
          end
          if (hit)         pend <= 1'b1;
          else if (!en[i]) pend <= 1'b0;
        end
      end
    end

    assign clk_out[i]     = clk_r;
    assign tick[i]        = tick_r;
    assign cfg_pending[i] = pend;
  end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed bench for clk_divider_bank: driver pushes expected {cfg_pending,tick,clk_out} per edge,
// a monitor pops and compares after each rising edge.
module tb_clk_divider_bank;
  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int W   = 3 * NCH;
  localparam logic [W-1:0] M_ALL = '1;
  localparam logic [W-1:0] M_OUT = {{NCH{1'b0}}, {(2*NCH){1'b1}}};

  logic           clk_input;
  logic           rst;
  logic [NCH-1:0] en;
  logic           load;
  logic [2:0]     load_ch;
  logic [CW-1:0]  load_period;
  logic [CW-1:0]  load_high;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] cfg_pending;
`ifdef DIVBANK_PHASE_ALIGN_EN
  logic           align;
`endif

  clk_divider_bank #(.NCH(NCH), .CW(CW), .DEF_PERIOD(10), .DEF_HIGH(5)) dut (
    .clk_input  (clk_input),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .load_ch    (load_ch),
    .load_period(load_period),
    .load_high  (load_high),
    .clk_out    (clk_out),
    .tick       (tick),
    .cfg_pending(cfg_pending)
`ifdef DIVBANK_PHASE_ALIGN_EN
    ,
    .align      (align)
`endif
  );

  // clock / reset
  initial clk_input = 1'b0;
  always #5 clk_input = ~clk_input;

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  string        tag_q[$];
  int           checks   = 0;
  int           failures = 0;

  logic [NCH-1:0] e_ck, e_tk, e_pd;

  initial begin
    logic [W-1:0] e, m, obs;
    string t;
    forever begin
      @(posedge clk_input);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        m   = msk_q.pop_front();
        t   = tag_q.pop_front();
        obs = {cfg_pending, tick, clk_out};
        checks++;
        if ((obs & m) !== (e & m)) begin
          failures++;
          $display("FAIL %s: got pend/tick/clk=%b required=%b (mask %b) t=%0t", t, obs, e, m, $time);
        end
      end
    end
  end

  // {tick, clk} expected at phase j of a period-p, high-h waveform
  function automatic logic [1:0] ph(input int j, input int p, input int h);
    int r;
    r = j % p;
    return {r == 0, r < h};
  endfunction

  task automatic set_exp(input int c, input logic [1:0] r);
    e_tk[c] = r[1];
    e_ck[c] = r[0];
  endtask

  task automatic step(input logic [W-1:0] m, input string tag);
    exp_q.push_back({e_pd, e_tk, e_ck});
    msk_q.push_back(m);
    tag_q.push_back(tag);
    @(negedge clk_input);
  endtask

  task automatic do_load(input int ch, input int p, input int h);
    load        = 1'b1;
    load_ch     = 3'(ch);
    load_period = CW'(p);
    load_high   = CW'(h);
  endtask

  task automatic zero_exp();
    e_ck = '0;
    e_tk = '0;
    e_pd = '0;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst = 1'b1; en = '0; load = 1'b0; load_ch = '0; load_period = '0; load_high = '0;
`ifdef DIVBANK_PHASE_ALIGN_EN
    align = 1'b0;
`endif
    zero_exp();
    step(M_ALL, "reset0");
    step(M_ALL, "reset1");

    // defaults, mid-period load on ch1, en[2] dropout, out-of-range load
    rst = 1'b0;
    for (int k = 0; k <= 690; k++) begin
      load = 1'b0;
      en   = 3'b111;
      if (k >= 42 && k <= 48) en[2] = 1'b0;
      if (k == 25)  do_load(1, 652, 326);
      if (k == 100) do_load(5, 3, 1);
      zero_exp();
      set_exp(0, ph(k, 10, 5));
      set_exp(1, (k < 30) ? ph(k, 10, 5) : ph(k - 30, 652, 326));
      if (k < 42)       set_exp(2, ph(k, 10, 5));
      else if (k <= 48) set_exp(2, 2'b00);
      else              set_exp(2, ph(k - 49, 10, 5));
      e_pd[1] = (k >= 25 && k <= 28);
      step(M_ALL, (k < 30) ? "default_run" : (k < 100) ? "ch1_long_period" : "bad_ch_load");
    end

    // clamp cases loaded while disabled
    load = 1'b0; en = '0; zero_exp();
    step(M_ALL, "disable_all");
    do_load(0, 0, 0); step(M_OUT, "dis_load0");
    do_load(1, 4, 4); step(M_OUT, "dis_load1");
    do_load(2, 4, 9); step(M_OUT, "dis_load2");
    load = 1'b0;      step(M_OUT, "dis_idle");
    step(M_ALL, "dis_applied");

    for (int j = 0; j <= 20; j++) begin
      load = 1'b0;
      en   = 3'b111;
      if (j == 7)  do_load(1, 6, 2);
      if (j == 20) do_load(0, 8, 4);
      zero_exp();
      set_exp(0, ph(j, 2, 0));
      set_exp(1, (j <= 7) ? ph(j, 4, 4) : ph(j - 8, 6, 2));
      set_exp(2, ph(j, 4, 9));
      e_pd[0] = (j == 20);
      step(M_ALL, (j <= 7) ? "clamp_run" : "wrap_load");
    end

    // reset mid-period discards the pending load on ch0
    load = 1'b0; rst = 1'b1; zero_exp();
    step(M_ALL, "mid_reset");
    rst = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      zero_exp();
      for (int c = 0; c < NCH; c++) set_exp(c, ph(k, 10, 5));
      step(M_ALL, "post_reset_defaults");
    end

`ifdef DIVBANK_PHASE_ALIGN_EN
    rst = 1'b1; zero_exp();
    step(M_ALL, "align_reset");
    rst = 1'b0;
    for (int k = 0; k <= 45; k++) begin
      load  = 1'b0;
      align = (k == 24);
      if (k == 3) do_load(0, 4, 2);
      zero_exp();
      if (k < 10)       set_exp(0, ph(k, 10, 5));
      else if (k <= 24) set_exp(0, ph(k - 10, 4, 2));
      else              set_exp(0, ph(k - 25, 4, 2));
      for (int c = 1; c < NCH; c++) set_exp(c, (k <= 24) ? ph(k, 10, 5) : ph(k - 25, 10, 5));
      e_pd[0] = (k >= 3 && k <= 8);
      step(M_ALL, "align_run");
    end
    align = 1'b0;
`endif

    load = 1'b0;
    @(negedge clk_input);
    @(negedge clk_input);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_divider_bank.md
# clk_divider_bank

Parametrised bank of NCH independent, runtime-programmable clock-enable dividers, all driven from the board input clock. It replaces the fixed-ratio divider that generates the CPU, UART-16x and VGA clocks. Each channel has its own period, high time and enable. Reconfiguration is glitch-free: new values take effect only at that channel's period boundary.

## Interface
Parameters:
- NCH, 3: number of divider channels (1..8).
- CW, 16: counter/config width in bits; periods up to 2^CW−1.
- DEF_PERIOD, 10: period in input cycles loaded into every channel at reset.
- DEF_HIGH, 5: high time in input cycles loaded into every channel at reset.

Ports:
- clk_input, in, 1: board clock; all logic is on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- en, in, NCH: per-channel run enable.
- load, in, 1: configuration write strobe, one cycle.
- load_ch, in, 3: target channel index for load.
- load_period, in, CW: new period P.
- load_high, in, CW: new high time H.
- clk_out, out, NCH: registered divided outputs.
- tick, out, NCH: registered one-cycle pulse on the first cycle of each period.
- cfg_pending, out, NCH: a loaded configuration is waiting for the period boundary.
- align, in, 1: present only with DIVBANK_PHASE_ALIGN_EN (see Configuration).

## Operation
- Per channel state:
  - cnt[CW]: phase counter.
  - Active config: act_P, act_H.
  - Shadow config: sh_P, sh_H.
  - pend: pending flag.
- Clamping on load: P<2 is stored as 2. H is stored as written.
  - H=0 gives a constant-low output.
  - H≥P gives a constant-high output.
- Enabled cycle (en[i]=1), evaluated from current state:
  - clk_out ← (cnt < act_H).
  - tick ← (cnt == 0).
  - cnt ← (cnt == act_P−1) ? 0 : cnt+1.
- Wrap (cnt == act_P−1 while enabled): if pend=1, act ← sh and pend ← 0. The new config governs the next period.
- Disabled cycle (en[i]=0):
  - clk_out ← 0, tick ← 0, cnt ← 0.
  - If pend=1, act ← sh and pend ← 0 immediately.
- Load (load=1, load_ch<NCH):
  - sh[load_ch] ← clamped values; pend ← 1.
  - load_ch≥NCH: ignored, no state change.
- Load in the same cycle as that channel's wrap: the newly loaded values become active at that wrap, and pend ends 0.
- A second load before the boundary overwrites the shadow. The last write wins.
- cfg_pending[i] = pend (registered).

## Timing
- Reset values:
  - clk_out=0, tick=0, cfg_pending=0, cnt=0.
  - act = sh = (DEF_PERIOD, DEF_HIGH), with the same clamping rules applied.
- First edge after reset release with en=1: clk_out=1 (if H>0) and tick=1.
- Output period is exactly P input cycles. clk_out is high for min(H,P) cycles, then low for the remainder.
- Latency from the en rising edge to the first tick: 1 edge.
- Latency from load to effect:
  - Enabled channel: the first period beginning after the current wrap.
  - Disabled channel: the next cycle.
- Reset mid-period: all channels return to reset values on that edge, and any pending loads are discarded.
- Channels are fully independent. Loads target one channel per cycle.

## Configuration
- DIVBANK_PHASE_ALIGN_EN defined:
  - Adds input align.
  - align=1 forces cnt←0 on every channel and applies any pending shadow.
  - align has no effect on clk_out or tick in that cycle.
  - On the next edge, every enabled channel emits tick=1 with clk_out=(H>0), phase-aligned.
  - align has lower priority than rst and higher priority than the wrap logic.
  - A load coincident with align is applied as well.
- Undefined: the align port and its logic are absent; channels phase only from reset or en.

## Test plan
- Reset, all en=1, defaults (10,5) → each clk_out repeats 5 high / 5 low; tick pulses every 10 cycles starting the first edge after reset.
- Channel 1 loaded with (652,326) mid-period → current 10-cycle period completes unchanged; cfg_pending[1]=1 until the wrap; then 326 high / 326 low.
- Loads of (0,0), (4,4) and (4,9) → respectively: P clamped to 2 with clk_out constantly 0; clk_out constantly 1 with tick every 4 cycles; clk_out constantly 1 with tick every 4 cycles.
- en[2] dropped for 7 cycles mid-high-phase → clk_out[2]=0 the next edge; on re-enable, tick and clk_out=1 the first edge, full new period follows.
- load with load_ch=5 at NCH=3 → no channel changes, cfg_pending stays 0; load coincident with wrap → new values active immediately, cfg_pending never asserts.
- With DIVBANK_PHASE_ALIGN_EN: channels at periods 4 and 10, align pulsed at arbitrary phase → both tick on the following edge, then every 4 and 10 cycles respectively.
